pes_intr_cntrl_param: RTL and testbench
=======================================

// Module: pes_intr_cntrl_param
// PURPOSE
//  Parametrised next-generation interrupt controller between NUM_CH request lines and one processor interrupt.
//  Adds round-robin or programmable fixed-priority arbitration, per-channel mask, and per-channel edge/level trigger.
//  Uses a split command/vector bus (bus_in/bus_out/bus_oe); the top level builds any tristate.
// PARAMETERS
//  NUM_CH   8        request channels, power of 2, 2..32
//  ID_W     3        $clog2(NUM_CH), channel id width
//  BUS_W    16       bus width, must be >= 2*ID_W+4
//  VEC_BASE 16'h0098 vector base; bus_out = {VEC_BASE[BUS_W-1:ID_W], id}
// PORTS
//  clk_in   in  1       clock, all logic on rising edge
//  rst_in   in  1       synchronous active-high reset
//  intr_rq  in  NUM_CH  interrupt requests, one per channel
//  bus_in   in  BUS_W   command word from processor
//  intr_in  in  1       active-low 1-cycle strobe: ack, or command-valid
//  intr_out out 1       interrupt to processor
//  bus_out  out BUS_W   vector to processor, valid while bus_oe=1
//  bus_oe   out 1       high while controller drives vector
// BEHAVIOUR
//  Reset: intr_out=0, bus_oe=0, bus_out=0, FSM=IDLE, mask=0, all channels level, mode=RR, rr_ptr=0, rank[c]=c.
//  Command: bus_in sampled when intr_in==0 in IDLE or WAIT_EOI; op=bus_in[BUS_W-1-:4], ch=bus_in[ID_W-1:0].
//  0x1 SET_MODE bit0: 0=round-robin, 1=fixed priority.
//  0x2 SET_PRIO rank=bus_in[2*ID_W-1:ID_W] for ch; rank 0 highest; equal ranks -> lower ch wins.
//  0x3 MASK_SET ch.  0x4 MASK_CLR ch.
//  0x5 TRIG bit ID_W: 1=edge, 0=level, for ch.
//  0xA EOI ch. All other ops are ignored.
//  Config changes take effect next cycle.
//  Pending: level ch -> intr_rq[c] & ~mask[c].
//  Edge ch -> rising edge (intr_rq vs 1-cycle-delayed copy) sets latch.
//  Latch clears when vectored; a masked latch is held, not lost.
//  Eligible = pending & ~in_service.
//  RR winner = first eligible from rr_ptr upward, wrapping at NUM_CH-1 -> 0; rr_ptr <= winner+1 (mod NUM_CH) at vectoring.
//  Fixed winner = lowest rank, ties to lower ch.
//  FSM IDLE: any eligible -> ASSERT; intr_out=1 from next cycle (1-cycle latency).
//  FSM ASSERT: winner re-evaluated each cycle.
//   Eligible drops to 0 before ack -> intr_out=0, IDLE.
//   intr_in==0 -> capture winner as in_service, clear its edge latch -> VECTOR.
//  FSM VECTOR: bus_oe=1, bus_out=vector from cycle after ack, held until next intr_in==0.
//   Then bus_oe=0, intr_out=0 -> WAIT_EOI.
//  FSM WAIT_EOI: commands accepted; EOI with ch==in_service clears in_service -> IDLE.
//   Mismatched EOI ignored.
//   Requests arriving here are latched and serviced after IDLE.
//  No nesting: one in-service channel max.
//  intr_in in ASSERT/VECTOR is always an ack, never a command.
//  Simultaneous edge and vectoring of the same ch: edge wins, latch stays set.
//  rst_in mid-operation: all state to reset values next cycle; bus_oe drops immediately on that edge.
// TESTING
//  RR: intr_rq=8'hAA, 4 full ack/vector/EOI cycles -> vectors 0x99,0x9B,0x9D,0x9F; then 8'h55 -> 0x98,0x9A,0x9C,0x9E.
//  Fixed: SET_MODE=1; ranks 5,3,7,0,4,2,6,1 -> rank0..7; intr_rq=8'hFF -> service order 5,3,7,0,4,2,6,1.
//   Re-raise ch3 after 4 services -> 3 is next.
//  Mask: MASK_SET ch2, intr_rq=8'h04 -> intr_out stays 0 for 20 cycles.
//   MASK_CLR ch2 -> intr_out=1 within 2 cycles, vector 0x9A.
//  Edge: TRIG edge ch6, 1-cycle pulse on intr_rq[6] -> serviced once (0x9E).
//   Held-high level with no new edge -> no re-interrupt after EOI.
//  Boundary: wrong-id EOI in WAIT_EOI -> stays WAIT_EOI.
//   Level drop during ASSERT -> intr_out=0, IDLE, no vector.
//   rst_in during VECTOR -> bus_oe=0, intr_out=0 next cycle.
//  Params: NUM_CH=16, BUS_W=16 -> RR wrap 15->0 correct; vector {VEC_BASE[15:4], id}.

Source files
------------

// File: rtl/pes_intr_cntrl_param.sv
// Parametrised interrupt controller: NUM_CH request lines to one CPU
// interrupt, with round-robin/fixed arbitration, masking and edge/level.
module pes_intr_cntrl_param #(
    parameter int               NUM_CH   = 8,
    parameter int               ID_W     = $clog2(NUM_CH),
    parameter int               BUS_W    = 16,
    parameter logic [BUS_W-1:0] VEC_BASE = 16'h0098
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] intr_rq,
    input  logic [BUS_W-1:0]  bus_in,
    input  logic              intr_in,
    output logic              intr_out,
    output logic [BUS_W-1:0]  bus_out,
    output logic              bus_oe
);

    localparam logic [3:0] OP_MODE = 4'h1;
    localparam logic [3:0] OP_PRIO = 4'h2;
    localparam logic [3:0] OP_MSET = 4'h3;
    localparam logic [3:0] OP_MCLR = 4'h4;
    localparam logic [3:0] OP_TRIG = 4'h5;
    localparam logic [3:0] OP_EOI  = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_VECTOR,
        S_WAIT_EOI
    } state_t;

    state_t state_q, state_d;

    logic              mode_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] edge_q;
    logic [NUM_CH-1:0] latch_q;
    logic [NUM_CH-1:0] latch_d;
    logic [NUM_CH-1:0] rq_d1_q;
    logic [ID_W-1:0]   rank_q [NUM_CH];
    logic [ID_W-1:0]   rr_q;
    logic              is_act_q;
    logic [ID_W-1:0]   is_id_q;
    logic [BUS_W-1:0]  vec_q;

    logic              cmd_ok;
    logic [3:0]        cmd_op;
    logic [ID_W-1:0]   cmd_ch;
    logic [ID_W-1:0]   cmd_rank;
    logic              do_mode;
    logic              do_prio;
    logic              do_mset;
    logic              do_mclr;
    logic              do_trig;
    logic              do_eoi;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] in_svc;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] clr_vec;
    logic              any_elig;

    logic              rr_found;
    logic [ID_W-1:0]   rr_win;
    logic [ID_W-1:0]   rr_idx;
    logic              fp_found;
    logic [ID_W-1:0]   fp_win;
    logic [ID_W-1:0]   fp_rank;
    logic [ID_W-1:0]   win;
    logic              take;
    logic              eoi_hit;

    logic              unused_bus;
    assign unused_bus = ^bus_in;

    // Commands are only decoded when the strobe cannot be an ack.
    assign cmd_ok   = ~intr_in & ((state_q == S_IDLE) | (state_q == S_WAIT_EOI));
    assign cmd_op   = bus_in[BUS_W-1 -: 4];
    assign cmd_ch   = bus_in[ID_W-1:0];
    assign cmd_rank = bus_in[2*ID_W-1:ID_W];

    always_comb begin
        do_mode = 1'b0;
        do_prio = 1'b0;
        do_mset = 1'b0;
        do_mclr = 1'b0;
        do_trig = 1'b0;
        do_eoi  = 1'b0;
        if (cmd_ok) begin
            case (cmd_op)
                OP_MODE: do_mode = 1'b1;
                OP_PRIO: do_prio = 1'b1;
                OP_MSET: do_mset = 1'b1;
                OP_MCLR: do_mclr = 1'b1;
                OP_TRIG: do_trig = 1'b1;
                OP_EOI:  do_eoi  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_q <= 1'b0;
            mask_q <= '0;
            edge_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rank_q[c] <= ID_W'(c);
            end
        end else begin
            if (do_mode) mode_q <= bus_in[0];
            if (do_prio) rank_q[cmd_ch] <= cmd_rank;
            if (do_mset) mask_q[cmd_ch] <= 1'b1;
            if (do_mclr) mask_q[cmd_ch] <= 1'b0;
            if (do_trig) edge_q[cmd_ch] <= bus_in[ID_W];
        end
    end

    // Latches keep running while masked so masked edges are not lost.
    assign pending = ((edge_q & latch_q) | (~edge_q & intr_rq)) & ~mask_q;

    always_comb begin
        in_svc = '0;
        if (is_act_q) in_svc[is_id_q] = 1'b1;
    end

    assign eligible = pending & ~in_svc;
    assign any_elig = |eligible;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = rr_q;
        rr_idx   = rr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_idx = rr_q + ID_W'(i);
            if (!rr_found && eligible[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    // Strict less-than keeps the lower channel on equal ranks.
    always_comb begin
        fp_found = 1'b0;
        fp_win   = '0;
        fp_rank  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (eligible[c] && (!fp_found || rank_q[c] < fp_rank)) begin
                fp_found = 1'b1;
                fp_win   = ID_W'(c);
                fp_rank  = rank_q[c];
            end
        end
    end

    assign win = mode_q ? fp_win : rr_win;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        eoi_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_elig) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                if (!any_elig) begin
                    state_d = S_IDLE;
                end else if (!intr_in) begin
                    take    = 1'b1;
                    state_d = S_VECTOR;
                end
            end
            S_VECTOR: begin
                if (!intr_in) state_d = S_WAIT_EOI;
            end
            S_WAIT_EOI: begin
                if (do_eoi && cmd_ch == is_id_q) begin
                    eoi_hit = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        clr_vec = '0;
        if (take) clr_vec[win] = 1'b1;
    end

    // A new edge in the vectoring cycle re-arms the latch.
    assign latch_d = (latch_q & ~clr_vec) | (intr_rq & ~rq_d1_q & edge_q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rq_d1_q  <= '0;
            latch_q  <= '0;
            rr_q     <= '0;
            is_act_q <= 1'b0;
            is_id_q  <= '0;
            vec_q    <= '0;
        end else begin
            rq_d1_q <= intr_rq;
            latch_q <= latch_d;
            if (take) begin
                is_act_q <= 1'b1;
                is_id_q  <= win;
                vec_q    <= {VEC_BASE[BUS_W-1:ID_W], win};
                rr_q     <= win + ID_W'(1);
            end else if (eoi_hit) begin
                is_act_q <= 1'b0;
            end
        end
    end

    assign intr_out = (state_q == S_ASSERT) | (state_q == S_VECTOR);
    assign bus_oe   = (state_q == S_VECTOR);
    assign bus_out  = bus_oe ? vec_q : '0;

endmodule

// File: tb/tb_pes_intr_cntrl_param.sv
// Directed bench for pes_intr_cntrl_param: 8-channel and
// 16-channel instances sharing one clock and reset.
module tb_pes_intr_cntrl_param;

    localparam int WAIT_MAX = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  intr_rq = '0;
    logic [15:0] bus_in = '0;
    logic        intr_in = 1'b1;
    logic        intr_out;
    logic        bus_oe;
    logic [15:0] bus_out;

    logic [15:0] intr_rq2 = '0;
    logic [15:0] bus_in2 = '0;
    logic        intr_in2 = 1'b1;
    logic        intr_out2;
    logic        bus_oe2;
    logic [15:0] bus_out2;

    int n_tests = 0;
    int n_fail  = 0;

    pes_intr_cntrl_param dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .intr_rq (intr_rq),
        .bus_in  (bus_in),
        .intr_in (intr_in),
        .intr_out(intr_out),
        .bus_out (bus_out),
        .bus_oe  (bus_oe)
    );

    pes_intr_cntrl_param #(
        .NUM_CH(16),
        .ID_W  (4),
        .BUS_W (16)
    ) dut16 (
        .clk_in  (clk),
        .rst_in  (rst),
        .intr_rq (intr_rq2),
        .bus_in  (bus_in2),
        .intr_in (intr_in2),
        .intr_out(intr_out2),
        .bus_out (bus_out2),
        .bus_oe  (bus_oe2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        intr_rq = '0;
        intr_rq2 = '0;
        intr_in = 1'b1;
        intr_in2 = 1'b1;
        bus_in = '0;
        bus_in2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cmd(input logic [3:0] op, input int arg, input int ch);
        bus_in = {op, 12'h000} | 16'(arg << 3) | 16'(ch);
        intr_in = 1'b0;
        @(negedge clk);
        intr_in = 1'b1;
        bus_in = '0;
    endtask

    task automatic eoi(input bit two, input int ch);
        if (two) begin
            bus_in2 = 16'hA000 | 16'(ch);
            intr_in2 = 1'b0;
            @(negedge clk);
            intr_in2 = 1'b1;
            bus_in2 = '0;
        end else begin
            cmd(4'hA, 0, ch);
        end
    endtask

    task automatic wait_irq(input bit two, output int cyc);
        cyc = 0;
        while (((two ? intr_out2 : intr_out) !== 1'b1) && cyc <= WAIT_MAX) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Ack, sample the vector, then the closing strobe.
    task automatic ack_vec(input bit two, output logic [15:0] vec,
                           output logic oe, output logic busy);
        if (two) intr_in2 = 1'b0;
        else     intr_in = 1'b0;
        @(negedge clk);
        intr_in = 1'b1;
        intr_in2 = 1'b1;
        vec = two ? bus_out2 : bus_out;
        oe  = two ? bus_oe2 : bus_oe;
        @(negedge clk);
        if (two) intr_in2 = 1'b0;
        else     intr_in = 1'b0;
        @(negedge clk);
        intr_in = 1'b1;
        intr_in2 = 1'b1;
        busy = two ? (intr_out2 | bus_oe2) : (intr_out | bus_oe);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        intr_rq = 8'hFF;
        repeat (2) @(negedge clk);
        n_tests++;
        if (intr_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_intr_out: got %b, required 0", intr_out);
        end
        n_tests++;
        if (bus_oe !== 1'b0 || bus_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: oe=%b out=%h, required 0/0000", bus_oe, bus_out);
        end
        do_reset();
    endtask

    task automatic test_rr();
        logic [15:0] exp_v [8];
        logic [15:0] v;
        logic        oe;
        logic        busy;
        int          cyc;
        exp_v = '{16'h99, 16'h9B, 16'h9D, 16'h9F, 16'h98, 16'h9A, 16'h9C, 16'h9E};
        do_reset();
        intr_rq = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) intr_rq = 8'h55;
            wait_irq(0, cyc);
            n_tests++;
            if (cyc > WAIT_MAX) begin
                n_fail++;
                $display("FAIL rr_irq[%0d]: intr_out stayed 0, required 1", i);
            end
            ack_vec(0, v, oe, busy);
            n_tests++;
            if (v !== exp_v[i] || oe !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_vec[%0d]: bus_out=%h oe=%b, required %h/1", i, v, oe, exp_v[i]);
            end
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_release[%0d]: intr_out|bus_oe=%b, required 0", i, busy);
            end
            eoi(0, int'(exp_v[i] - 16'h98));
        end
        intr_rq = '0;
    endtask

    task automatic test_fixed();
        int          order [8];
        int          seq [9];
        logic [15:0] v;
        logic [15:0] exp;
        logic        oe;
        logic        busy;
        int          cyc;
        order = '{5, 3, 7, 0, 4, 2, 6, 1};
        seq   = '{5, 3, 7, 0, 3, 4, 2, 6, 1};
        do_reset();
        cmd(4'h1, 0, 1);
        for (int r = 0; r < 8; r++) cmd(4'h2, r, order[r]);
        intr_rq = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) intr_rq[3] = 1'b1;
            exp = 16'h0098 + 16'(seq[i]);
            wait_irq(0, cyc);
            n_tests++;
            if (cyc > WAIT_MAX) begin
                n_fail++;
                $display("FAIL fp_irq[%0d]: intr_out stayed 0, required 1", i);
            end
            ack_vec(0, v, oe, busy);
            n_tests++;
            if (v !== exp || oe !== 1'b1) begin
                n_fail++;
                $display("FAIL fp_vec[%0d]: bus_out=%h oe=%b, required %h/1", i, v, oe, exp);
            end
            intr_rq[seq[i]] = 1'b0;
            eoi(0, seq[i]);
        end
        intr_rq = '0;
    endtask

    task automatic test_mask();
        logic [15:0] v;
        logic        oe;
        logic        busy;
        int          cyc;
        int          hits;
        do_reset();
        cmd(4'h3, 0, 2);
        intr_rq = 8'h04;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (intr_out !== 1'b0) hits++;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL mask_hold: intr_out high %0d cycles, required 0", hits);
        end
        cmd(4'h4, 0, 2);
        wait_irq(0, cyc);
        n_tests++;
        if (cyc > 2) begin
            n_fail++;
            $display("FAIL mask_clr_latency: %0d cycles, required <= 2", cyc);
        end
        ack_vec(0, v, oe, busy);
        n_tests++;
        if (v !== 16'h009A || oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_vec: bus_out=%h oe=%b, required 009a/1", v, oe);
        end
        intr_rq = '0;
        eoi(0, 2);
    endtask

    task automatic test_edge();
        logic [15:0] v;
        logic        oe;
        logic        busy;
        int          cyc;
        int          hits;
        do_reset();
        cmd(4'h5, 1, 6);
        for (int k = 0; k < 2; k++) begin
            intr_rq[6] = 1'b1;
            if (k == 0) begin
                @(negedge clk);
                intr_rq[6] = 1'b0;
            end
            wait_irq(0, cyc);
            n_tests++;
            if (cyc > WAIT_MAX) begin
                n_fail++;
                $display("FAIL edge_irq[%0d]: intr_out stayed 0, required 1", k);
            end
            ack_vec(0, v, oe, busy);
            n_tests++;
            if (v !== 16'h009E || oe !== 1'b1) begin
                n_fail++;
                $display("FAIL edge_vec[%0d]: bus_out=%h oe=%b, required 009e/1", k, v, oe);
            end
            eoi(0, 6);
            hits = 0;
            repeat (10) begin
                @(negedge clk);
                if (intr_out !== 1'b0) hits++;
            end
            n_tests++;
            if (hits != 0) begin
                n_fail++;
                $display("FAIL edge_once[%0d]: re-interrupt %0d cycles, required 0", k, hits);
            end
        end
        intr_rq = '0;
    endtask

    task automatic test_boundary();
        logic [15:0] v;
        logic        oe;
        logic        busy;
        int          cyc;
        int          hits;
        do_reset();
        intr_rq = 8'h10;
        wait_irq(0, cyc);
        ack_vec(0, v, oe, busy);
        n_tests++;
        if (v !== 16'h009C) begin
            n_fail++;
            $display("FAIL bnd_vec: bus_out=%h, required 009c", v);
        end
        eoi(0, 3);
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (intr_out !== 1'b0) hits++;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL bnd_wrong_eoi: intr_out high %0d cycles, required 0", hits);
        end
        eoi(0, 4);
        wait_irq(0, cyc);
        n_tests++;
        if (cyc > 2) begin
            n_fail++;
            $display("FAIL bnd_right_eoi: re-assert took %0d cycles, required <= 2", cyc);
        end
        intr_rq = '0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (intr_out !== 1'b0 || bus_oe !== 1'b0) hits++;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL bnd_level_drop: busy %0d cycles, required 0", hits);
        end
        intr_rq = 8'h02;
        wait_irq(0, cyc);
        intr_in = 1'b0;
        @(negedge clk);
        intr_in = 1'b1;
        n_tests++;
        if (bus_oe !== 1'b1 || bus_out !== 16'h0099) begin
            n_fail++;
            $display("FAIL bnd_pre_rst: oe=%b out=%h, required 1/0099", bus_oe, bus_out);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_oe !== 1'b0 || intr_out !== 1'b0 || bus_out !== 16'h0) begin
            n_fail++;
            $display("FAIL bnd_rst_vector: oe=%b irq=%b out=%h, required 0/0/0000",
                     bus_oe, intr_out, bus_out);
        end
        intr_rq = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_params();
        logic [15:0] exp_v [3];
        int          exp_ch [3];
        logic [15:0] v;
        logic        oe;
        logic        busy;
        int          cyc;
        exp_v  = '{16'h009E, 16'h009F, 16'h0090};
        exp_ch = '{14, 15, 0};
        do_reset();
        intr_rq2 = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            wait_irq(1, cyc);
            n_tests++;
            if (cyc > WAIT_MAX) begin
                n_fail++;
                $display("FAIL p16_irq[%0d]: intr_out stayed 0, required 1", i);
            end
            ack_vec(1, v, oe, busy);
            n_tests++;
            if (v !== exp_v[i] || oe !== 1'b1) begin
                n_fail++;
                $display("FAIL p16_vec[%0d]: bus_out=%h oe=%b, required %h/1", i, v, oe, exp_v[i]);
            end
            if (i == 0) intr_rq2 = 16'h8001;
            if (i == 1) intr_rq2 = 16'h4001;
            if (i == 2) intr_rq2 = 16'h0000;
            eoi(1, exp_ch[i]);
        end
    endtask

    initial begin
        test_reset();
        test_rr();
        test_fixed();
        test_mask();
        test_edge();
        test_boundary();
        test_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
